// File: rtl/miner_job_regs_if.sv
// Byte-wide register bus between a host and miner_job_regs.
// Fixed one-cycle read latency; no backpressure, every strobe is accepted.
interface miner_job_regs_if;
    logic [7:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (output addr, wr_en, wr_data, rd_en, input rd_data, rd_valid);
    modport slave  (input addr, wr_en, wr_data, rd_en, output rd_data, rd_valid);
endinterface

// File: rtl/miner_job_regs.sv
// Job shadow/active registers, nonce snapshot and found tracking for the hashing cores.
// Reads return one edge after rd_en; commit lands one edge after CMD; hold defers commit, no bus backpressure.
module miner_job_regs #(
    parameter int NUM_CORES = 4,
    parameter int JOB_BYTES = 76,
    parameter int JOB_BASE  = 8'h10
) (
    input  logic                     clk,
    input  logic                     reset,
    miner_job_regs_if.slave          bus,
    input  logic [3*NUM_CORES-1:0]   core_state,
    input  logic [32*NUM_CORES-1:0]  core_nonce,
    input  logic [NUM_CORES-1:0]     found,
    input  logic                     hold,
    output logic [8*JOB_BYTES-1:0]   job_active,
    output logic                     job_load
);

    logic [7:0]  shadow [JOB_BYTES];
    logic [3:0]  sel;
    logic [3:0]  found_core;
    logic        pending;
    logic        commit_req;
    logic        found_sticky;
    logic [31:0] snapshot;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;

    logic [2:0]  sel_state;
    logic [31:0] sel_nonce;
    logic [3:0]  found_low;
    logic [7:0]  job_byte;
    logic        job_hit;
    logic [7:0]  rd_mux;
    logic        wr_cmd;
    logic        clr_found;
    logic        commit_exec;
    logic        take_snap;

    always_comb begin
        sel_state = 3'd0;
        sel_nonce = 32'd0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (int'(sel) == c) begin
                sel_state = core_state[3*c +: 3];
                sel_nonce = core_nonce[32*c +: 32];
            end
        end
        // Descending scan so the lowest set index is the one that sticks.
        found_low = 4'd0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (found[c]) found_low = 4'(c);
        end
        job_byte = 8'd0;
        job_hit  = 1'b0;
        for (int k = 0; k < JOB_BYTES; k++) begin
            if (int'(bus.addr) == JOB_BASE + k) begin
                job_byte = shadow[k];
                job_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = job_byte;
        case (bus.addr)
            8'h00: rd_mux = {pending, found_sticky, commit_req, 2'b00, sel_state};
            8'h01: rd_mux = {4'd0, sel};
            8'h02: rd_mux = 8'd0;
            8'h03: rd_mux = sel_nonce[31:24];
            8'h04: rd_mux = snapshot[23:16];
            8'h05: rd_mux = snapshot[15:8];
            8'h06: rd_mux = snapshot[7:0];
            8'h07: rd_mux = {4'd0, found_core};
            default: rd_mux = job_byte;
        endcase
    end

    assign wr_cmd      = bus.wr_en && (bus.addr == 8'h02);
    assign clr_found   = wr_cmd && bus.wr_data[1];
    assign commit_exec = commit_req && !hold;
    assign take_snap   = (bus.rd_en && (bus.addr == 8'h03)) || (wr_cmd && bus.wr_data[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < JOB_BYTES; k++) shadow[k] <= 8'd0;
            job_active   <= '0;
            job_load     <= 1'b0;
            sel          <= 4'd0;
            found_core   <= 4'd0;
            pending      <= 1'b0;
            commit_req   <= 1'b0;
            found_sticky <= 1'b0;
            snapshot     <= 32'd0;
            rd_data_q    <= 8'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;

            for (int k = 0; k < JOB_BYTES; k++) begin
                if (bus.wr_en && int'(bus.addr) == JOB_BASE + k) shadow[k] <= bus.wr_data;
            end

            // Copy takes the pre-write shadow; a same-edge write keeps pending set.
            job_load <= commit_exec;
            if (commit_exec) begin
                for (int k = 0; k < JOB_BYTES; k++) job_active[8*k +: 8] <= shadow[k];
            end
            if (bus.wr_en && job_hit) pending <= 1'b1;
            else if (commit_exec)     pending <= 1'b0;

            if (commit_exec)                       commit_req <= 1'b0;
            else if (wr_cmd && bus.wr_data[0])     commit_req <= 1'b1;

            if (bus.wr_en && bus.addr == 8'h01 && int'(bus.wr_data) < NUM_CORES)
                sel <= bus.wr_data[3:0];

            if (take_snap) snapshot <= sel_nonce;

            if (|found) begin
                found_sticky <= 1'b1;
                if (!found_sticky || clr_found) found_core <= found_low;
            end else if (clr_found) begin
                found_sticky <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_miner_job_regs.sv
module tb_miner_job_regs;
    localparam int NC    = 4;
    localparam int JBY   = 76;
    localparam int JBASE = 8'h10;

    typedef logic [7:0] jarr_t [JBY];

    logic                clk = 1'b0;
    logic                reset;
    logic [3*NC-1:0]     core_state;
    logic [32*NC-1:0]    core_nonce;
    logic [NC-1:0]       found;
    logic                hold;
    logic [8*JBY-1:0]    job_active;
    logic                job_load;

    miner_job_regs_if bus();

    miner_job_regs #(.NUM_CORES(NC), .JOB_BYTES(JBY), .JOB_BASE(JBASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .core_state (core_state),
        .core_nonce (core_nonce),
        .found      (found),
        .hold       (hold),
        .job_active (job_active),
        .job_load   (job_load)
    );

    always #5 clk = ~clk;

    // Reference model: register file as plain arrays and flags.
    jarr_t       m_sh, m_job;
    logic [3:0]  m_sel, m_fc;
    bit          m_pend, m_creq, m_st;
    logic [31:0] m_snap;
    logic [7:0]  m_rdlast;
    bit          m_rdv, m_jl;
    logic [2:0]  cs [NC];
    logic [31:0] nn [NC];
    bit          started = 0;

    logic [7:0]       rdq  [$];
    logic [7:0]       rdaq [$];
    logic [8*JBY-1:0] jobq [$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_job(input string nm, input logic [8*JBY-1:0] act, input logic [8*JBY-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [8*JBY-1:0] pack(input jarr_t a);
        logic [8*JBY-1:0] v;
        for (int k = 0; k < JBY; k++) v[8*k +: 8] = a[k];
        return v;
    endfunction

    function automatic logic [7:0] mread(input logic [7:0] a);
        int ia;
        ia = int'(a);
        case (ia)
            0: return {m_pend, m_st, m_creq, 2'b00, cs[m_sel]};
            1: return {4'd0, m_sel};
            3: return nn[m_sel][31:24];
            4: return m_snap[23:16];
            5: return m_snap[15:8];
            6: return m_snap[7:0];
            7: return {4'd0, m_fc};
            default: return (ia >= JBASE && ia < JBASE + JBY) ? m_sh[ia - JBASE] : 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] lowest(input logic [NC-1:0] f);
        for (int i = 0; i < NC; i++) if (f[i]) return 4'(i);
        return 4'd0;
    endfunction

    bit g_hold = 0;

    // One clock edge: drive inputs, then advance the model with the spec rules.
    task automatic cyc(input bit rst, input logic [7:0] a, input bit we, input logic [7:0] wd,
                       input bit re, input logic [NC-1:0] f, input bit h);
        logic [31:0] snap_n;
        bit          ex, clr;
        int          ia;
        ia = int'(a);
        reset = rst; bus.addr = a; bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re;
        found = f; hold = h;
        for (int c = 0; c < NC; c++) begin
            core_state[3*c +: 3]  = cs[c];
            core_nonce[32*c +: 32] = nn[c];
        end
        @(posedge clk);
        m_jl = 0; m_rdv = 0;
        if (rst) begin
            for (int k = 0; k < JBY; k++) begin m_sh[k] = 8'd0; m_job[k] = 8'd0; end
            m_sel = 0; m_fc = 0; m_pend = 0; m_creq = 0; m_st = 0; m_snap = 0; m_rdlast = 0;
        end else begin
            snap_n = m_snap;
            ex     = m_creq && !h;
            clr    = we && ia == 2 && wd[1];
            if (re) begin
                m_rdv = 1; m_rdlast = mread(a);
                rdq.push_back(m_rdlast); rdaq.push_back(a);
                if (ia == 3) snap_n = nn[m_sel];
            end
            if (ex) begin
                jobq.push_back(pack(m_sh));
                m_job = m_sh; m_jl = 1; m_creq = 0; m_pend = 0;
            end
            if (we) begin
                if (ia >= JBASE && ia < JBASE + JBY) begin m_sh[ia - JBASE] = wd; m_pend = 1; end
                if (ia == 2) begin
                    if (wd[2]) snap_n = nn[m_sel];
                    if (wd[0] && !ex) m_creq = 1;
                end
                if (ia == 1 && int'(wd) < NC) m_sel = wd[3:0];
            end
            if (|f) begin
                if (!m_st || clr) m_fc = lowest(f);
                m_st = 1;
            end else if (clr) m_st = 0;
            m_snap = snap_n;
        end
        #1;
        if (rst) started = 1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d); cyc(0, a, 1, d, 0, '0, g_hold); endtask
    task automatic rd(input logic [7:0] a);                       cyc(0, a, 0, 8'h00, 1, '0, g_hold); endtask
    task automatic idle();                                        cyc(0, 8'h00, 0, 8'h00, 0, '0, g_hold); endtask

    // Monitor: pops expectations as the DUT presents reads/commits.
    always @(negedge clk) begin
        if (started) begin
            check("rd_valid", bus.rd_valid, m_rdv);
            if (bus.rd_valid && rdq.size() > 0)
                check($sformatf("rd_data@%02h", rdaq.pop_front()), bus.rd_data, rdq.pop_front());
            check("rd_data_hold", bus.rd_data, m_rdlast);
            check("job_load", job_load, m_jl);
            if (job_load && jobq.size() > 0) check_job("job_commit", job_active, jobq.pop_front());
            else                             check_job("job_active", job_active, pack(m_job));
        end
    end

    initial begin
        for (int c = 0; c < NC; c++) begin cs[c] = 3'(c + 1); nn[c] = $urandom; end
        cyc(1, 8'h00, 0, 8'h00, 0, '0, 0);
        cyc(1, 8'h00, 0, 8'h00, 0, '0, 0);
        for (int a = 0; a < 8; a++) rd(8'(a));
        rd(8'(JBASE)); rd(8'(JBASE + JBY - 1));

        // Commit path with hold low.
        wr(8'(JBASE + 3), 8'hA5); wr(8'h02, 8'h01); rd(8'h00); idle(); rd(8'h00);

        // Held commit plus write while held.
        g_hold = 1; wr(8'h02, 8'h01); wr(8'(JBASE), 8'h3C);
        for (int i = 0; i < 10; i++) idle();
        wr(8'h02, 8'h01);
        g_hold = 0; idle(); idle(); rd(8'h00);

        // Nonce snapshot isolation.
        wr(8'h01, 8'h02); nn[2] = 32'h12345678; rd(8'h03); nn[2] = 32'h0;
        rd(8'h04); rd(8'h05); rd(8'h06); wr(8'h01, 8'h01); rd(8'h04);

        // Found sticky and clear-vs-set.
        cyc(0, 8'h00, 0, 8'h00, 0, 4'b1010, 0); cyc(0, 8'h00, 0, 8'h00, 0, 4'b0001, 0);
        rd(8'h00); rd(8'h07);
        cyc(0, 8'h02, 1, 8'h02, 0, 4'b0100, 0); rd(8'h00); rd(8'h07);
        wr(8'h02, 8'h02); rd(8'h00);

        // Out-of-range CORE_SEL, unmapped reads, same-cycle rd/wr.
        wr(8'h01, 8'h07); rd(8'h01); rd(8'hFF); wr(8'hFF, 8'h55); rd(8'hFF);
        cyc(0, 8'(JBASE + 5), 1, 8'h77, 1, '0, 0); rd(8'(JBASE + 5));

        // Commit execution racing a shadow write.
        g_hold = 1; wr(8'h02, 8'h01); g_hold = 0;
        wr(8'(JBASE + 9), 8'hEE); rd(8'h00); wr(8'h02, 8'h07); idle(); rd(8'h00);

        // Reset mid-sequence with commit pending.
        g_hold = 1; wr(8'(JBASE + 1), 8'h99); wr(8'h02, 8'h01);
        cyc(1, 8'h02, 1, 8'h01, 1, 4'b1111, 0); g_hold = 0; idle();
        for (int a = 0; a < 8; a++) rd(8'(a));
        for (int k = 0; k < JBY; k++) rd(8'(JBASE + k));

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] a, d;
            logic [NC-1:0] f;
            int r;
            if ($urandom_range(0, 7) == 0) begin
                int c = $urandom_range(0, NC - 1);
                cs[c] = 3'($urandom); nn[c] = $urandom;
            end
            r = $urandom_range(0, 9);
            if (r < 5)      a = 8'($urandom_range(0, 7));
            else if (r < 9) a = 8'(JBASE + $urandom_range(0, JBY - 1));
            else            a = 8'($urandom);
            d = 8'($urandom);
            if (a == 8'h01) d = 8'($urandom_range(0, 9));
            f = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
            cyc($urandom_range(0, 299) == 0, a, $urandom_range(0, 1) == 1, d,
                $urandom_range(0, 1) == 1, f, $urandom_range(0, 3) == 0);
        end
        g_hold = 0;
        for (int i = 0; i < 4; i++) idle();
        check("rd_queue_drained", 64'(rdq.size()), 64'd0);
        check("job_queue_drained", 64'(jobq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
